// File: rtl/nibble_serial_addsub_seq.sv
// WIDTH-bit add/subtract sequencer driving one external 4-bit adder slice, LS nibble first.
// Optional signed saturation of the result when NIBSEQ_SAT_EN is defined.
module nibble_serial_addsub_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_s,
    input  logic             add_co
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_addsub_seq: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

`ifdef NIBSEQ_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] y_sh_q, y_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic             run;
    logic             last;
    logic             ovf_now;

    assign run  = (state_q == S_RUN);
    assign last = (cnt_q == CW'(NIB - 1));

    // Carry into the MSB is a^b^s at bit 3; xor with carry out flags signed overflow.
    assign ovf_now = a_sh_q[3] ^ b_sh_q[3] ^ add_s[3] ^ add_co;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        y_sh_d  = y_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                y_sh_d             = y_sh_q >> 4;
                y_sh_d[WIDTH-1-:4] = add_s;
                carry_d            = add_co;
                a_sh_d             = a_sh_q >> 4;
                b_sh_d             = b_sh_q >> 4;
                cnt_d              = cnt_q + CW'(1);
                if (last) begin
                    co_d    = add_co;
                    ovf_d   = ovf_now;
                    state_d = S_DONE;
`ifdef NIBSEQ_SAT_EN
                    if (ovf_now) begin
                        y_sh_d = a_sh_q[3] ? SAT_NEG : SAT_POS;
                    end
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            y_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            y_sh_q  <= y_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Slice inputs stay quiet outside RUN so a shared adder sees no activity.
    assign add_a     = run ? a_sh_q[3:0] : 4'h0;
    assign add_b     = run ? b_sh_q[3:0] : 4'h0;
    assign add_ci    = run ? carry_q : 1'b0;
    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = (state_q == S_DONE);
    assign y         = y_sh_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule
